bist_sequencer: RTL and testbench

- Upstream controller for the `bist` engine. It runs a selected set of BIST patterns back to back, one at a time.
- For each pattern it does three things:
  - drives the BIST reset, enable and pattern select;
  - waits for `done`, with a timeout;
  - records pass/fail for that pattern.
- It presents an aggregate status to the SoC/scan side, so software issues one `start` instead of sequencing each BIST run by hand.

---
 rtl/bist_sequencer_if.sv | 39 +++
 rtl/bist_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_bist_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_sequencer_if.sv
// Bundle of sequencer control/status and BIST-engine handshake signals.
// master = sequencer view, slave = SoC/engine-side view.
interface bist_sequencer_if #(
  parameter int NUM_PATTERNS  = 4,
  parameter int PATTERN_WIDTH = 2
);
  logic                     start;
  logic [NUM_PATTERNS-1:0]  pattern_mask;
  logic                     stop_on_fail;
  logic                     busy;
  logic                     seq_done;
  logic [NUM_PATTERNS-1:0]  pass_vec;
  logic [NUM_PATTERNS-1:0]  fail_vec;
  logic [NUM_PATTERNS-1:0]  timeout_vec;
  logic                     first_fail_valid;
  logic [PATTERN_WIDTH-1:0] first_fail_pattern;
  logic                     bist_rst;
  logic                     bist_en;
  logic [PATTERN_WIDTH-1:0] bist_pattern_sel;
  logic                     bist_done;
  logic                     bist_fail;
  logic [PATTERN_WIDTH-1:0] bist_fail_pattern;

  modport master (
    input  start, pattern_mask, stop_on_fail,
    input  bist_done, bist_fail, bist_fail_pattern,
    output busy, seq_done, pass_vec, fail_vec, timeout_vec,
    output first_fail_valid, first_fail_pattern,
    output bist_rst, bist_en, bist_pattern_sel
  );

  modport slave (
    output start, pattern_mask, stop_on_fail,
    output bist_done, bist_fail, bist_fail_pattern,
    input  busy, seq_done, pass_vec, fail_vec, timeout_vec,
    input  first_fail_valid, first_fail_pattern,
    input  bist_rst, bist_en, bist_pattern_sel
  );
endinterface

// File: rtl/bist_sequencer.sv
// BIST sequencer: runs the selected BIST patterns one at a time (reset,
// run with timeout, record) and keeps an aggregate pass/fail status.
// Every output is a flop; all state resets synchronously.
module bist_sequencer #(
  parameter int NUM_PATTERNS   = 4,
  parameter int PATTERN_WIDTH  = 2,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst,
  bist_sequencer_if.master  bus
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [PATTERN_WIDTH-1:0] LAST_IDX  = PATTERN_WIDTH'(NUM_PATTERNS - 1);
  localparam logic [RCW-1:0]           RCNT_LOAD = RCW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]            TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_BRESET = 3'd2,
    S_RUN    = 3'd3,
    S_RECORD = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [PATTERN_WIDTH-1:0] idx_q, idx_d;
  logic [NUM_PATTERNS-1:0]  mask_q, mask_d;
  logic                     stop_q, stop_d;
  logic [RCW-1:0]           rcnt_q, rcnt_d;
  logic [TW-1:0]            tcnt_q, tcnt_d;
  // Result of the run that just ended, consumed in RECORD
  logic                     cap_fail_q, cap_fail_d;
  logic                     cap_to_q, cap_to_d;
  logic [PATTERN_WIDTH-1:0] cap_pat_q, cap_pat_d;
  // Registered outputs
  logic                     busy_q, busy_d;
  logic                     seq_done_q, seq_done_d;
  logic [NUM_PATTERNS-1:0]  pass_q, pass_d;
  logic [NUM_PATTERNS-1:0]  fail_q, fail_d;
  logic [NUM_PATTERNS-1:0]  to_q, to_d;
  logic                     ffv_q, ffv_d;
  logic [PATTERN_WIDTH-1:0] ffp_q, ffp_d;
  logic                     brst_q, brst_d;
  logic                     ben_q, ben_d;
  logic [PATTERN_WIDTH-1:0] bsel_q, bsel_d;

  // Next-state and next-output logic for the sequencing FSM
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    stop_d     = stop_q;
    rcnt_d     = rcnt_q;
    tcnt_d     = tcnt_q;
    cap_fail_d = cap_fail_q;
    cap_to_d   = cap_to_q;
    cap_pat_d  = cap_pat_q;
    busy_d     = busy_q;
    seq_done_d = seq_done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    to_d       = to_q;
    ffv_d      = ffv_q;
    ffp_d      = ffp_q;
    brst_d     = brst_q;
    ben_d      = ben_q;
    bsel_d     = bsel_q;

    case (state_q)
      S_IDLE: begin
        brst_d = 1'b1;
        ben_d  = 1'b0;
        if (bus.start) begin
          // Either way a new request wipes the previous sequence's status
          pass_d     = '0;
          fail_d     = '0;
          to_d       = '0;
          ffv_d      = 1'b0;
          ffp_d      = '0;
          if (bus.pattern_mask != '0) begin
            mask_d     = bus.pattern_mask;
            stop_d     = bus.stop_on_fail;
            seq_done_d = 1'b0;
            busy_d     = 1'b1;
            idx_d      = '0;
            state_d    = S_SELECT;
          end else begin
            // Nothing to run: report completion without ever going busy
            seq_done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SELECT: begin
        if (mask_q[idx_q]) begin
          bsel_d  = idx_q;
          rcnt_d  = RCNT_LOAD;
          brst_d  = 1'b1;
          ben_d   = 1'b0;
          state_d = S_BRESET;
        end else if (idx_q == LAST_IDX) begin
          busy_d     = 1'b0;
          seq_done_d = 1'b1;
          brst_d     = 1'b1;
          state_d    = S_FINISH;
        end else begin
          idx_d = idx_q + PATTERN_WIDTH'(1);
        end
      end

      S_BRESET: begin
        if (rcnt_q == '0) begin
          brst_d  = 1'b0;
          ben_d   = 1'b1;
          tcnt_d  = '0;
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
        end
      end

      S_RUN: begin
        // A completion on the last allowed cycle still counts as completion
        if (bus.bist_done) begin
          cap_fail_d = bus.bist_fail;
          cap_to_d   = 1'b0;
          cap_pat_d  = bus.bist_fail_pattern;
          ben_d      = 1'b0;
          brst_d     = 1'b1;
          state_d    = S_RECORD;
        end else if (tcnt_q == TCNT_LAST) begin
          cap_fail_d = 1'b1;
          cap_to_d   = 1'b1;
          cap_pat_d  = idx_q;
          ben_d      = 1'b0;
          brst_d     = 1'b1;
          state_d    = S_RECORD;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      S_RECORD: begin
        if (cap_fail_q) begin
          fail_d[idx_q] = 1'b1;
          if (cap_to_q) begin
            to_d[idx_q] = 1'b1;
          end else begin
            to_d = to_q;
          end
          // Only the first failure of a sequence is reported
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffp_d = cap_pat_q;
          end else begin
            ffv_d = ffv_q;
          end
        end else begin
          pass_d[idx_q] = 1'b1;
        end
        if ((cap_fail_q && stop_q) || (idx_q == LAST_IDX)) begin
          busy_d     = 1'b0;
          seq_done_d = 1'b1;
          state_d    = S_FINISH;
        end else begin
          idx_d   = idx_q + PATTERN_WIDTH'(1);
          state_d = S_SELECT;
        end
      end

      S_FINISH: begin
        brst_d  = 1'b1;
        ben_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mask_q     <= '0;
      stop_q     <= 1'b0;
      rcnt_q     <= '0;
      tcnt_q     <= '0;
      cap_fail_q <= 1'b0;
      cap_to_q   <= 1'b0;
      cap_pat_q  <= '0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      to_q       <= '0;
      ffv_q      <= 1'b0;
      ffp_q      <= '0;
      brst_q     <= 1'b1;
      ben_q      <= 1'b0;
      bsel_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      stop_q     <= stop_d;
      rcnt_q     <= rcnt_d;
      tcnt_q     <= tcnt_d;
      cap_fail_q <= cap_fail_d;
      cap_to_q   <= cap_to_d;
      cap_pat_q  <= cap_pat_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      to_q       <= to_d;
      ffv_q      <= ffv_d;
      ffp_q      <= ffp_d;
      brst_q     <= brst_d;
      ben_q      <= ben_d;
      bsel_q     <= bsel_d;
    end
  end

  assign bus.busy               = busy_q;
  assign bus.seq_done           = seq_done_q;
  assign bus.pass_vec           = pass_q;
  assign bus.fail_vec           = fail_q;
  assign bus.timeout_vec        = to_q;
  assign bus.first_fail_valid   = ffv_q;
  assign bus.first_fail_pattern = ffp_q;
  assign bus.bist_rst           = brst_q;
  assign bus.bist_en            = ben_q;
  assign bus.bist_pattern_sel   = bsel_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer: a behavioural BIST engine model
// plus a pattern-level reference of the expected sequence outcome.
module tb_bist_sequencer;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int RC = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bist_sequencer_if #(.NUM_PATTERNS(NP), .PATTERN_WIDTH(PW)) bus ();

  bist_sequencer #(
    .NUM_PATTERNS(NP), .PATTERN_WIDTH(PW),
    .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Engine behaviour per pattern
  int          lat_tab [NP];
  logic [PW-1:0] fp_tab [NP];
  logic [NP-1:0] fail_cfg = '0;
  logic [NP-1:0] hang_cfg = '0;
  int          force_lat = 0;

  // Monitor state
  int run_cnt = 0, pre_cnt = 0, en_cnt = 0;
  bit prev_en = 1'b0, busy_seen = 1'b0, en_seen = 1'b0;
  int mon_runs[$], mon_pre[$], mon_en[$];

  // Advance one clock; sample at the falling edge, then drive the engine.
  task automatic cycle();
    logic d;
    int s;
    @(negedge clk);
    total++;
    if (((bus.pass_vec & bus.fail_vec) !== '0) || ((bus.timeout_vec & ~bus.fail_vec) !== '0) ||
        (bus.bist_en === 1'b1 && bus.bist_rst === 1'b1)) begin
      bad++;
      $display("FAIL invariant: pass=%b fail=%b to=%b en=%b rst=%b (required disjoint/subset, en&rst=0)",
               bus.pass_vec, bus.fail_vec, bus.timeout_vec, bus.bist_en, bus.bist_rst);
    end
    if (bus.busy) busy_seen = 1'b1;
    if (bus.bist_en) en_seen = 1'b1;
    if (bus.bist_en && !prev_en) begin
      mon_runs.push_back(int'(bus.bist_pattern_sel));
      mon_pre.push_back(pre_cnt);
      en_cnt = 0;
    end
    if (bus.bist_en) en_cnt++;
    if (!bus.bist_en && prev_en) mon_en.push_back(en_cnt);
    pre_cnt = (bus.busy && bus.bist_rst && !bus.bist_en) ? pre_cnt + 1 : 0;
    prev_en = bus.bist_en;
    s = int'(bus.bist_pattern_sel);
    if (bus.bist_en) begin
      run_cnt++;
      d = !hang_cfg[s] && (run_cnt == lat_tab[s]);
    end else begin
      run_cnt = 0;
      d = 1'b0;
    end
    bus.bist_done         = d;
    bus.bist_fail         = d ? fail_cfg[s] : 1'($urandom_range(0, 1));
    bus.bist_fail_pattern = d ? fp_tab[s] : PW'($urandom);
  endtask

  // Run one full sequence and compare against the pattern-level reference.
  task automatic run_seq(input string tag, input logic [NP-1:0] mask, input bit stop,
                         input bit rand_fp, input bit poke);
    logic [NP-1:0] e_pass, e_fail, e_to;
    logic e_ffv;
    logic [PW-1:0] e_ffp;
    int e_runs[$], e_pre[$], e_en[$];
    int last, n;
    bit failed, ok;
    e_pass = '0; e_fail = '0; e_to = '0; e_ffv = 1'b0; e_ffp = '0; last = -1;
    for (int i = 0; i < NP; i++) begin
      lat_tab[i] = (force_lat > 0) ? force_lat : int'($urandom_range(1, 40));
      fp_tab[i]  = rand_fp ? PW'($urandom) : PW'(i);
    end
    for (int i = 0; i < NP; i++) begin
      if (mask[i]) begin
        e_runs.push_back(i);
        e_en.push_back(hang_cfg[i] ? TO : lat_tab[i]);
        // busy cycles with BIST held in reset before enable: one per mask
        // slot scanned, one for recording the previous run, plus the reset hold
        e_pre.push_back((last < 0) ? (i + 1 + RC) : (1 + (i - last) + RC));
        last = i;
        failed = hang_cfg[i] || fail_cfg[i];
        if (failed) begin
          e_fail[i] = 1'b1;
          if (hang_cfg[i]) e_to[i] = 1'b1;
          if (!e_ffv) begin
            e_ffv = 1'b1;
            e_ffp = hang_cfg[i] ? PW'(i) : fp_tab[i];
          end
        end else begin
          e_pass[i] = 1'b1;
        end
        if (failed && stop) break;
      end
    end
    mon_runs.delete(); mon_pre.delete(); mon_en.delete();
    busy_seen = 1'b0; en_seen = 1'b0;
    bus.pattern_mask = mask; bus.stop_on_fail = stop; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.pattern_mask = NP'($urandom);
    bus.stop_on_fail = 1'($urandom_range(0, 1));
    n = 0;
    while (!bus.seq_done && n < 3000) begin
      if (poke && n == 25) begin
        bus.start = 1'b1;
        bus.pattern_mask = ~mask;
        bus.stop_on_fail = ~stop;
      end else begin
        bus.start = 1'b0;
      end
      cycle();
      n++;
    end
    bus.start = 1'b0;
    total++;
    if (bus.seq_done !== 1'b1) begin
      bad++; $display("FAIL %s seq_done: got %b after %0d cycles, required 1", tag, bus.seq_done, n);
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s busy_end: got %b required 0", tag, bus.busy); end
    total++;
    if (bus.pass_vec !== e_pass) begin bad++; $display("FAIL %s pass_vec: got %b required %b", tag, bus.pass_vec, e_pass); end
    total++;
    if (bus.fail_vec !== e_fail) begin bad++; $display("FAIL %s fail_vec: got %b required %b", tag, bus.fail_vec, e_fail); end
    total++;
    if (bus.timeout_vec !== e_to) begin bad++; $display("FAIL %s timeout_vec: got %b required %b", tag, bus.timeout_vec, e_to); end
    total++;
    if (bus.first_fail_valid !== e_ffv) begin
      bad++; $display("FAIL %s ffv: got %b required %b", tag, bus.first_fail_valid, e_ffv);
    end
    if (e_ffv) begin
      total++;
      if (bus.first_fail_pattern !== e_ffp) begin
        bad++; $display("FAIL %s ffp: got %0d required %0d", tag, bus.first_fail_pattern, e_ffp);
      end
    end
    ok = (mon_runs.size() == e_runs.size()) && (mon_pre.size() == e_pre.size()) && (mon_en.size() == e_en.size());
    if (ok) begin
      foreach (e_runs[k]) if (mon_runs[k] != e_runs[k] || mon_pre[k] != e_pre[k] || mon_en[k] != e_en[k]) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s runs: got sel=%p pre=%p en=%p required sel=%p pre=%p en=%p",
               tag, mon_runs, mon_pre, mon_en, e_runs, e_pre, e_en);
    end
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    total++;
    if ({bus.busy, bus.seq_done, bus.pass_vec, bus.fail_vec, bus.timeout_vec, bus.first_fail_valid,
         bus.first_fail_pattern, bus.bist_en, bus.bist_pattern_sel} !== '0 || bus.bist_rst !== 1'b1) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b p=%b f=%b t=%b ffv=%b ffp=%0d en=%b sel=%0d rst=%b, required zeros and bist_rst=1",
               bus.busy, bus.seq_done, bus.pass_vec, bus.fail_vec, bus.timeout_vec, bus.first_fail_valid,
               bus.first_fail_pattern, bus.bist_en, bus.bist_pattern_sel, bus.bist_rst);
    end
    rst = 1'b0;
    repeat (3) cycle();
    total++;
    if (bus.bist_rst !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL idle_hold: bist_rst=%b busy=%b required 1/0", bus.bist_rst, bus.busy);
    end
  endtask

  task automatic test_pass_two();
    fail_cfg = '0; hang_cfg = '0;
    run_seq("pass0011", 4'b0011, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.pass_vec !== 4'b0011 || mon_runs.size() != 2 || mon_pre.size() != 2 || mon_pre[0] != 17 || mon_pre[1] != 18) begin
      bad++; $display("FAIL pass0011_direct: pass=%b runs=%0d pre=%p required 0011/2/'{17,18}", bus.pass_vec, mon_runs.size(), mon_pre);
    end
  endtask

  task automatic test_fail_continue();
    fail_cfg = 4'b0100; hang_cfg = '0;
    run_seq("fail2_nostop", 4'b1111, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.pass_vec !== 4'b1011 || bus.fail_vec !== 4'b0100 || bus.first_fail_pattern !== 2'd2 || mon_runs.size() != 4) begin
      bad++; $display("FAIL fail2_nostop_direct: p=%b f=%b ffp=%0d runs=%0d required 1011/0100/2/4",
                      bus.pass_vec, bus.fail_vec, bus.first_fail_pattern, mon_runs.size());
    end
  endtask

  task automatic test_fail_stop();
    fail_cfg = 4'b0100; hang_cfg = '0;
    run_seq("fail2_stop", 4'b1111, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.pass_vec !== 4'b0011 || bus.fail_vec !== 4'b0100 || mon_runs.size() != 3) begin
      bad++; $display("FAIL fail2_stop_direct: p=%b f=%b runs=%0d required 0011/0100/3", bus.pass_vec, bus.fail_vec, mon_runs.size());
    end
  endtask

  task automatic test_timeout();
    fail_cfg = '0; hang_cfg = 4'b0001;
    run_seq("timeout", 4'b0001, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.fail_vec !== 4'b0001 || bus.timeout_vec !== 4'b0001 || bus.first_fail_pattern !== 2'd0 ||
        mon_en.size() != 1 || mon_en[0] != 64) begin
      bad++; $display("FAIL timeout_direct: f=%b t=%b ffp=%0d en_len=%p required 0001/0001/0/'{64}",
                      bus.fail_vec, bus.timeout_vec, bus.first_fail_pattern, mon_en);
    end
    hang_cfg = '0;
  endtask

  task automatic test_done_at_limit();
    fail_cfg = '0; hang_cfg = '0; force_lat = TO;
    run_seq("done_at_limit", 4'b0100, 1'b0, 1'b0, 1'b0);
    force_lat = 0;
  endtask

  task automatic test_empty_mask();
    busy_seen = 1'b0; en_seen = 1'b0;
    bus.start = 1'b1; bus.pattern_mask = '0;
    cycle();
    bus.start = 1'b0;
    total++;
    if (bus.seq_done !== 1'b1 || {bus.pass_vec, bus.fail_vec, bus.timeout_vec, bus.first_fail_valid} !== '0) begin
      bad++; $display("FAIL empty_mask: done=%b p=%b f=%b t=%b ffv=%b required 1 and zeros",
                      bus.seq_done, bus.pass_vec, bus.fail_vec, bus.timeout_vec, bus.first_fail_valid);
    end
    repeat (20) cycle();
    total++;
    if (busy_seen || en_seen) begin
      bad++; $display("FAIL empty_mask_quiet: busy_seen=%b en_seen=%b required 0/0", busy_seen, en_seen);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    fail_cfg = '0; hang_cfg = '0;
    for (int i = 0; i < NP; i++) begin lat_tab[i] = 40; fp_tab[i] = PW'(i); end
    bus.start = 1'b1; bus.pattern_mask = 4'b1111; bus.stop_on_fail = 1'b0;
    cycle();
    bus.start = 1'b0;
    n = 0;
    while (!(bus.bist_en && bus.bist_pattern_sel == 2'd1) && n < 500) begin cycle(); n++; end
    total++;
    if (!(bus.bist_en && bus.bist_pattern_sel == 2'd1)) begin
      bad++; $display("FAIL mid_reset_reach: en=%b sel=%0d required 1/1", bus.bist_en, bus.bist_pattern_sel);
    end
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    total++;
    if ({bus.busy, bus.seq_done, bus.pass_vec, bus.fail_vec, bus.timeout_vec, bus.first_fail_valid,
         bus.first_fail_pattern, bus.bist_en, bus.bist_pattern_sel} !== '0 || bus.bist_rst !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: busy=%b done=%b p=%b f=%b en=%b sel=%0d rst=%b required zeros and bist_rst=1",
               bus.busy, bus.seq_done, bus.pass_vec, bus.fail_vec, bus.bist_en, bus.bist_pattern_sel, bus.bist_rst);
    end
    rst = 1'b0;
    repeat (5) cycle();
    total++;
    if (bus.busy !== 1'b0 || bus.bist_en !== 1'b0 || bus.pass_vec !== '0) begin
      bad++; $display("FAIL mid_reset_after: busy=%b en=%b pass=%b required 0/0/0", bus.busy, bus.bist_en, bus.pass_vec);
    end
  endtask

  task automatic test_start_while_busy();
    fail_cfg = 4'b0010; hang_cfg = '0;
    run_seq("start_busy", 4'b1011, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [NP-1:0] m;
    for (int it = 0; it < 12; it++) begin
      m = NP'($urandom_range(1, (1 << NP) - 1));
      fail_cfg = NP'($urandom);
      hang_cfg = NP'($urandom) & NP'($urandom) & NP'($urandom);
      run_seq($sformatf("rand%0d", it), m, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    hang_cfg = '0;
  endtask

  initial begin
    bus.start = 1'b0; bus.pattern_mask = '0; bus.stop_on_fail = 1'b0;
    bus.bist_done = 1'b0; bus.bist_fail = 1'b0; bus.bist_fail_pattern = '0;
    for (int i = 0; i < NP; i++) begin lat_tab[i] = 1; fp_tab[i] = '0; end
    test_reset();
    test_pass_two();
    test_fail_continue();
    test_fail_stop();
    test_timeout();
    test_empty_mask();
    test_done_at_limit();
    test_mid_reset();
    test_start_while_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
